// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the three-requester memory arbiter.
// Requester indices, request count, FSM state encoding and index helpers.
package mem_arbiter_pkg;

  localparam int unsigned NUM_REQ    = 3;
  localparam int unsigned IDX_W      = 2;

  localparam int unsigned REQ_LOADER = 0;
  localparam int unsigned REQ_CPU    = 1;
  localparam int unsigned REQ_DEBUG  = 2;

  typedef logic [IDX_W-1:0]   req_idx_t;
  typedef logic [NUM_REQ-1:0] req_vec_t;

  typedef enum logic [1:0] {
    ST_ARB    = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_t;

  // Requester index advanced by off positions, wrapping modulo NUM_REQ.
  function automatic req_idx_t wrap_idx(input req_idx_t base, input int unsigned off);
    int unsigned sum;
    sum = 32'(base) + off;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    if (sum >= NUM_REQ) sum = sum - NUM_REQ;
    return req_idx_t'(sum);
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_select.sv
// Combinational winner selection for the memory arbiter.
// Round-robin search starting at rr_ptr. When MEM_ARB_LOADER_PRIO_EN is
// defined the loader wins outright whenever it requests, and the remaining
// requesters rotate among themselves.
module mem_arbiter_rr_select
  import mem_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] winner,
  output logic [IDX_W-1:0]   winner_idx,
  output logic               found
);

  logic [NUM_REQ-1:0] pool;
  req_idx_t           cand;

  // First requesting index at or after rr_ptr wins.
  always_comb begin
    winner     = '0;
    winner_idx = '0;
    found      = 1'b0;
    pool       = req;
    cand       = '0;
`ifdef MEM_ARB_LOADER_PRIO_EN
    if (req[REQ_LOADER]) begin
      winner[REQ_LOADER] = 1'b1;
      winner_idx         = req_idx_t'(REQ_LOADER);
      found              = 1'b1;
    end
    // Loader removed from the rotation: a pointer aimed at it simply falls
    // through to the next requester.
    pool[REQ_LOADER] = 1'b0;
`endif
    for (int unsigned off = 0; off < NUM_REQ; off++) begin
      cand = wrap_idx(rr_ptr, off);
      if (!found && pool[cand]) begin
        winner[cand] = 1'b1;
        winner_idx   = cand;
        found        = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Three-requester arbiter in front of a single-port synchronous RAM.
// One access outstanding: ARB picks and latches a request, ACCESS drives the
// RAM and pulses gnt, RESP (reads only) returns data with an rvalid pulse.
// Optional build macro: MEM_ARB_LOADER_PRIO_EN (loader has absolute priority).
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned WORD_SIZE     = 8,
  parameter int unsigned MEM_ADDR_SIZE = 8
) (
  input  logic                             clock,
  input  logic                             reset,
  input  logic [NUM_REQ-1:0]               req,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*MEM_ADDR_SIZE-1:0] req_addr,
  input  logic [NUM_REQ*WORD_SIZE-1:0]     req_wdata,
  output logic [NUM_REQ-1:0]               gnt,
  output logic [NUM_REQ-1:0]               rvalid,
  output logic [WORD_SIZE-1:0]             rdata,
  output logic [MEM_ADDR_SIZE-1:0]         mem_addr,
  output logic [WORD_SIZE-1:0]             mem_write_data,
  output logic                             mem_write,
  input  logic [WORD_SIZE-1:0]             mem_read_data,
  output logic                             busy
);

  arb_state_t               state;
  arb_state_t               state_next;
  req_idx_t                 rr_ptr;

  logic [NUM_REQ-1:0]       lat_gnt;
  logic                     lat_we;
  logic [MEM_ADDR_SIZE-1:0] lat_addr;
  logic [WORD_SIZE-1:0]     lat_wdata;
  logic [WORD_SIZE-1:0]     rdata_q;

  logic [NUM_REQ-1:0]       sel_winner;
  req_idx_t                 sel_idx;
  logic                     sel_found;
  logic                     take;

  mem_arbiter_rr_select u_rr_select (
    .req        (req),
    .rr_ptr     (rr_ptr),
    .winner     (sel_winner),
    .winner_idx (sel_idx),
    .found      (sel_found)
  );

  assign take = (state == ST_ARB) && sel_found;

  // State register; reset drops straight back to ARB, aborting any access.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= ST_ARB;
    else        state <= state_next;
  end

  // Capture the winner's request in ARB and advance the rotation past it.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rr_ptr    <= '0;
      lat_gnt   <= '0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
    end else if (take) begin
      rr_ptr    <= wrap_idx(sel_idx, 1);
      lat_gnt   <= sel_winner;
      lat_we    <= req_we[sel_idx];
      lat_addr  <= req_addr[32'(sel_idx)*MEM_ADDR_SIZE +: MEM_ADDR_SIZE];
      lat_wdata <= req_wdata[32'(sel_idx)*WORD_SIZE +: WORD_SIZE];
    end
  end

  // Keep the last returned read word so rdata holds between responses.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                rdata_q <= '0;
    else if (state == ST_RESP) rdata_q <= mem_read_data;
  end

  // Next-state and per-state strobes; every output is decoded from state so
  // reset clears them without waiting for a clock edge.
  always_comb begin
    state_next = state;
    gnt        = '0;
    rvalid     = '0;
    mem_write  = 1'b0;
    rdata      = rdata_q;
    case (state)
      ST_ARB: begin
        if (sel_found) state_next = ST_ACCESS;
      end
      ST_ACCESS: begin
        gnt        = lat_gnt;
        mem_write  = lat_we;
        state_next = lat_we ? ST_ARB : ST_RESP;
      end
      ST_RESP: begin
        rvalid     = lat_gnt;
        rdata      = mem_read_data;
        state_next = ST_ARB;
      end
      default: begin
        state_next = ST_ARB;
      end
    endcase
  end

  assign mem_addr       = lat_addr;
  assign mem_write_data = lat_wdata;
  assign busy           = (state != ST_ARB);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed testbench for mem_arbiter with a behavioural synchronous RAM.
// Honours MEM_ARB_LOADER_PRIO_EN for the grant-order expectations.
module tb_mem_arbiter;

  localparam int W = 8;
  localparam int A = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic [2:0]     req;
  logic [2:0]     req_we;
  logic [3*A-1:0] req_addr;
  logic [3*W-1:0] req_wdata;
  logic [2:0]     gnt;
  logic [2:0]     rvalid;
  logic [W-1:0]   rdata;
  logic [A-1:0]   mem_addr;
  logic [W-1:0]   mem_write_data;
  logic           mem_write;
  logic [W-1:0]   mem_read_data;
  logic           busy;

  logic [W-1:0]   ram [256];

  int tests = 0;
  int fails = 0;

  mem_arbiter #(.WORD_SIZE(W), .MEM_ADDR_SIZE(A)) dut (
    .clock          (clock),
    .reset          (reset),
    .req            (req),
    .req_we         (req_we),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .gnt            (gnt),
    .rvalid         (rvalid),
    .rdata          (rdata),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read_data  (mem_read_data),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (mem_write) ram[mem_addr] <= mem_write_data;
    mem_read_data <= ram[mem_addr];
  end

  initial begin
    for (int i = 0; i < 256; i++) ram[i] <= 8'(i * 7 + 1);
    ram[8'h05] <= 8'h3C;
    ram[8'h06] <= 8'h77;
    ram[8'h20] <= 8'h11;
  end

  task automatic do_reset();
    reset     = 1'b0;
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    req       = 3'b111;
    req_we    = 3'b001;
    req_addr  = {8'h33, 8'h22, 8'h11};
    req_wdata = {8'hCC, 8'hBB, 8'hAA};
    @(negedge clock);
    @(negedge clock);
    tests++; if (gnt !== 3'b000) begin fails++; $display("FAIL reset_gnt got %b want 000", gnt); end
    tests++; if (rvalid !== 3'b000) begin fails++; $display("FAIL reset_rvalid got %b want 000", rvalid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", busy); end
    tests++; if (mem_write !== 1'b0) begin fails++; $display("FAIL reset_mem_write got %b want 0", mem_write); end
    tests++; if (mem_addr !== 8'h00) begin fails++; $display("FAIL reset_mem_addr got %h want 00", mem_addr); end
    tests++; if (mem_write_data !== 8'h00) begin fails++; $display("FAIL reset_wdata got %h want 00", mem_write_data); end
    tests++; if (rdata !== 8'h00) begin fails++; $display("FAIL reset_rdata got %h want 00", rdata); end
    req    = '0;
    req_we = '0;
    reset  = 1'b1;
    @(negedge clock);
  endtask

  task automatic test_single_read();
    do_reset();
    req_we = 3'b000;
    req_addr[1*A +: A] = 8'h05;
    req = 3'b010;
    @(negedge clock);
    tests++; if (gnt !== 3'b010) begin fails++; $display("FAIL read_gnt got %b want 010", gnt); end
    tests++; if (mem_addr !== 8'h05) begin fails++; $display("FAIL read_addr got %h want 05", mem_addr); end
    tests++; if (mem_write !== 1'b0) begin fails++; $display("FAIL read_mem_write got %b want 0", mem_write); end
    tests++; if (busy !== 1'b1) begin fails++; $display("FAIL read_busy got %b want 1", busy); end
    tests++; if (rvalid !== 3'b000) begin fails++; $display("FAIL read_early_rvalid got %b want 000", rvalid); end
    req = 3'b000;
    @(negedge clock);
    tests++; if (rvalid !== 3'b010) begin fails++; $display("FAIL read_rvalid got %b want 010", rvalid); end
    tests++; if (rdata !== 8'h3C) begin fails++; $display("FAIL read_rdata got %h want 3c", rdata); end
    tests++; if (gnt !== 3'b000) begin fails++; $display("FAIL read_gnt_resp got %b want 000", gnt); end
    @(negedge clock);
    tests++; if (rvalid !== 3'b000) begin fails++; $display("FAIL read_rvalid_after got %b want 000", rvalid); end
    tests++; if (rdata !== 8'h3C) begin fails++; $display("FAIL read_rdata_hold got %h want 3c", rdata); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL read_busy_after got %b want 0", busy); end
  endtask

  task automatic test_single_write();
    do_reset();
    req_we = 3'b001;
    req_addr[0 +: A]  = 8'h10;
    req_wdata[0 +: W] = 8'hA5;
    req = 3'b001;
    @(negedge clock);
    tests++; if (gnt !== 3'b001) begin fails++; $display("FAIL write_gnt got %b want 001", gnt); end
    tests++; if (mem_write !== 1'b1) begin fails++; $display("FAIL write_strobe got %b want 1", mem_write); end
    tests++; if (mem_addr !== 8'h10) begin fails++; $display("FAIL write_addr got %h want 10", mem_addr); end
    tests++; if (mem_write_data !== 8'hA5) begin fails++; $display("FAIL write_data got %h want a5", mem_write_data); end
    req    = 3'b000;
    req_we = 3'b000;
    @(negedge clock);
    tests++; if (mem_write !== 1'b0) begin fails++; $display("FAIL write_strobe_len got %b want 0", mem_write); end
    tests++; if (rvalid !== 3'b000) begin fails++; $display("FAIL write_rvalid got %b want 000", rvalid); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL write_busy got %b want 0", busy); end
    tests++; if (ram[8'h10] !== 8'hA5) begin fails++; $display("FAIL write_ram got %h want a5", ram[8'h10]); end
  endtask

  task automatic test_round_robin();
    int         exp_seq[8];
    int         n;
    int         last;
    int         widx;
    logic [2:0] prev_gnt;
    logic [7:0] exp_data;
`ifdef MEM_ARB_LOADER_PRIO_EN
    exp_seq = '{0, 0, 0, 0, 0, 0, 1, 2};
`else
    exp_seq = '{0, 1, 2, 0, 1, 2, 0, 1};
`endif
    do_reset();
    req_addr = {8'h03, 8'h02, 8'h01};
    req_we   = 3'b000;
    req      = 3'b111;
    n        = 0;
    last     = 0;
    prev_gnt = '0;
    exp_data = '0;
    for (int cyc = 0; cyc < 40 && n < 8; cyc++) begin
      @(negedge clock);
      if (prev_gnt != 3'b000) begin
        tests++;
        if (rvalid !== prev_gnt || rdata !== exp_data) begin
          fails++;
          $display("FAIL rr_resp got rvalid=%b rdata=%h want rvalid=%b rdata=%h", rvalid, rdata, prev_gnt, exp_data);
        end
      end
      prev_gnt = gnt;
      if (gnt != 3'b000) begin
        widx = (gnt == 3'b001) ? 0 : (gnt == 3'b010) ? 1 : (gnt == 3'b100) ? 2 : -1;
        tests++;
        if (widx != exp_seq[n]) begin
          fails++;
          $display("FAIL rr_order grant %0d got gnt=%b want requester %0d", n, gnt, exp_seq[n]);
        end
        tests++;
        if (cyc != ((n == 0) ? 0 : last + 3)) begin
          fails++;
          $display("FAIL rr_spacing grant %0d at cycle %0d want %0d", n, cyc, (n == 0) ? 0 : last + 3);
        end
        exp_data = ram[8'(exp_seq[n] + 1)];
        last = cyc;
        n++;
`ifdef MEM_ARB_LOADER_PRIO_EN
        if (n == 6) req[0] = 1'b0;
`endif
      end
    end
    tests++; if (n != 8) begin fails++; $display("FAIL rr_timeout got %0d grants want 8", n); end
    req = 3'b000;
    @(negedge clock);
    tests++; if (rvalid !== prev_gnt) begin fails++; $display("FAIL rr_last_rvalid got %b want %b", rvalid, prev_gnt); end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    logic [2:0] exp_g;
    do_reset();
    req_we = 3'b010;
    req_addr[1*A +: A]  = 8'h30;
    req_wdata[1*W +: W] = 8'h40;
    req = 3'b010;
    for (int i = 0; i < 6; i++) begin
      @(negedge clock);
      exp_g = (i % 2 == 0) ? 3'b010 : 3'b000;
      tests++; if (gnt !== exp_g) begin fails++; $display("FAIL b2b_gnt cycle %0d got %b want %b", i, gnt, exp_g); end
      tests++; if (mem_write !== exp_g[1]) begin fails++; $display("FAIL b2b_write cycle %0d got %b want %b", i, mem_write, exp_g[1]); end
      tests++; if (rvalid !== 3'b000) begin fails++; $display("FAIL b2b_rvalid cycle %0d got %b want 000", i, rvalid); end
    end
    req    = 3'b000;
    req_we = 3'b000;
    @(negedge clock);
    tests++; if (ram[8'h30] !== 8'h40) begin fails++; $display("FAIL b2b_ram got %h want 40", ram[8'h30]); end
  endtask

  task automatic test_reset_mid_write();
    do_reset();
    req_we = 3'b001;
    req_addr[0 +: A]  = 8'h20;
    req_wdata[0 +: W] = 8'hEE;
    req = 3'b001;
    @(negedge clock);
    tests++; if (mem_write !== 1'b1) begin fails++; $display("FAIL rst_mid_pre_write got %b want 1", mem_write); end
    #1;
    reset = 1'b0;
    #1;
    tests++; if (mem_write !== 1'b0) begin fails++; $display("FAIL rst_mid_write got %b want 0", mem_write); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_busy got %b want 0", busy); end
    tests++; if (gnt !== 3'b000) begin fails++; $display("FAIL rst_mid_gnt got %b want 000", gnt); end
    tests++; if (mem_addr !== 8'h00) begin fails++; $display("FAIL rst_mid_addr got %h want 00", mem_addr); end
    req    = 3'b000;
    req_we = 3'b000;
    @(posedge clock);
    #1;
    tests++; if (ram[8'h20] !== 8'h11) begin fails++; $display("FAIL rst_mid_ram got %h want 11", ram[8'h20]); end
    tests++; if (rvalid !== 3'b000) begin fails++; $display("FAIL rst_mid_rvalid got %b want 000", rvalid); end
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_mid_idle got %b want 0", busy); end
  endtask

  task automatic test_addr_change();
    do_reset();
    req_we = 3'b000;
    req_addr[1*A +: A] = 8'h05;
    req = 3'b010;
    @(negedge clock);
    tests++; if (gnt !== 3'b010) begin fails++; $display("FAIL addrchg_gnt got %b want 010", gnt); end
    req_addr[1*A +: A] = 8'h06;
    req = 3'b000;
    #1;
    tests++; if (mem_addr !== 8'h05) begin fails++; $display("FAIL addrchg_addr got %h want 05", mem_addr); end
    @(negedge clock);
    tests++; if (rvalid !== 3'b010) begin fails++; $display("FAIL addrchg_rvalid got %b want 010", rvalid); end
    tests++; if (rdata !== 8'h3C) begin fails++; $display("FAIL addrchg_rdata got %h want 3c", rdata); end
  endtask

  initial begin
    reset     = 1'b0;
    req       = '0;
    req_we    = '0;
    req_addr  = '0;
    req_wdata = '0;
    test_reset();
    test_single_read();
    test_single_write();
    test_round_robin();
    test_back_to_back();
    test_reset_mid_write();
    test_addr_change();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
